// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sequencer state encoding, PC mux select codes and default PC width
package cpu_pkg;
  localparam int PC_W_DEF = 10;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_e;
  typedef enum logic [1:0] {SEL_INC = 2'd0, SEL_BR = 2'd1, SEL_JMP = 2'd2, SEL_HOLD = 2'd3} sel_e;
endpackage

// File: rtl/pc_next_logic.sv
// pc_next_logic: combinational next-PC selection, priority halt > jump > branch > PC+1
// Ports: pc_i current PC; retire_i instruction retires this cycle; halt_i/jump_i/branch_i
// redirect requests with jump_target_i/branch_target_i; next_pc_o candidate PC; pc_sel_o mux code.
module pc_next_logic
  import cpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            retire_i,
  input  logic            halt_i,
  input  logic            jump_i,
  input  logic [PC_W-1:0] jump_target_i,
  input  logic            branch_i,
  input  logic [PC_W-1:0] branch_target_i,
  output logic [PC_W-1:0] next_pc_o,
  output logic [1:0]      pc_sel_o
);
  sel_e sel;
  always_comb begin
    sel = (!retire_i || halt_i) ? SEL_HOLD : jump_i ? SEL_JMP : branch_i ? SEL_BR : SEL_INC;
    next_pc_o = sel == SEL_INC ? pc_i + 1'b1 :
                sel == SEL_BR  ? branch_target_i :
                sel == SEL_JMP ? jump_target_i : pc_i;
    pc_sel_o = sel;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute FSM owning the PC, the imem handshake and a saturating retire counter
// Ports: clk, reset (async active-low); start, imem_ack, exec_done, stall, branch_taken/branch_target,
// jump/jump_target, halt from control; pc, next_pc, pc_sel, imem_req, imem_addr, instr_valid,
// halted, retired to the datapath and instruction memory.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int          PC_W      = PC_W_DEF,
  parameter int unsigned RESET_VEC = 0,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             imem_ack,
  input  logic             exec_done,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             jump,
  input  logic [PC_W-1:0]  jump_target,
  input  logic             halt,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  next_pc,
  output logic [1:0]       pc_sel,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  output logic             instr_valid,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, retire;
  assign retire = state_q == EXEC && exec_done && !stall;
  pc_next_logic #(.PC_W(PC_W)) u_next (
    .pc_i(pc_q), .retire_i(retire), .halt_i(halt),
    .jump_i(jump), .jump_target_i(jump_target),
    .branch_i(branch_taken), .branch_target_i(branch_target),
    .next_pc_o(next_pc), .pc_sel_o(pc_sel)
  );
  always_comb begin
    state_d = state_q == IDLE  ? (start ? FETCH : IDLE) :
              state_q == FETCH ? (imem_ack ? EXEC : FETCH) :
              state_q == EXEC  ? (retire ? (halt ? HALTED : FETCH) : EXEC) : HALTED;
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire && !(&cnt_q)};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= PC_W'(RESET_VEC);
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= next_pc;
      cnt_q   <= cnt_d;
      valid_q <= state_q == FETCH && imem_ack;
    end
  end
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = state_q == FETCH;
  assign halted      = state_q == HALTED;
  assign instr_valid = valid_q;
  assign retired     = cnt_q;
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

- Multi-cycle fetch/execute sequencer that owns the program counter (PC) update and the instruction-memory fetch handshake for the teaching CPU.
- Each cycle it computes the next PC from the PC+1, branch and jump sources, and publishes the select code it used for the PC mux.
- It holds the PC during stalls and halts, and counts retired instructions.
- It sits between the control unit (`exec_done`, `branch_taken`, `jump`, `halt`) and instruction memory.

## Interface
Parameters:
- `PC_W`, 10: PC and target address width.
- `RESET_VEC`, 0: PC value loaded on reset.
- `CNT_W`, 16: retired-instruction counter width.

Ports (`reset` is asynchronous, active-low):
- `clk`  in  1  system clock, all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  leave IDLE and begin fetching.
- `imem_ack`  in  1  instruction memory has returned data for `imem_addr`.
- `exec_done`  in  1  control unit has finished the current instruction.
- `stall`  in  1  hold the current instruction in EXEC.
- `branch_taken`  in  1  redirect to `branch_target` at retire.
- `branch_target`  in  `PC_W`  branch destination.
- `jump`  in  1  redirect to `jump_target` at retire.
- `jump_target`  in  `PC_W`  jump destination.
- `halt`  in  1  stop after the current instruction.
- `pc`  out  `PC_W`  registered current PC.
- `next_pc`  out  `PC_W`  combinational candidate PC for the next cycle.
- `pc_sel`  out  2  mux select: 0 = PC+1, 1 = branch, 2 = jump, 3 = hold.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  `PC_W`  fetch address, always equal to `pc`.
- `instr_valid`  out  1  one-cycle pulse when fetched data is accepted.
- `halted`  out  1  sequencer is in HALTED.
- `retired`  out  `CNT_W`  saturating count of retired instructions.

## Operation
States:
- IDLE → FETCH when `start`=1.
- FETCH: `imem_req`=1. On `imem_ack`=1, go to EXEC and register `instr_valid`=1 for exactly one cycle.
- EXEC: the instruction retires on `exec_done`=1 and `stall`=0.
  - At retire with `halt`=1: go to HALTED, PC holds.
  - Otherwise: go to FETCH and update the PC.
- HALTED: sticky. Exit only through `reset`; `start` is ignored.

PC update at retire, priority halt > jump > branch > PC+1:
- `pc_sel` = 3 (hold) in every state and cycle where no retire occurs.
- Retire with halt: `pc_sel` = 3.
- Retire with `jump`: `pc_sel` = 2.
- Retire with `branch_taken`: `pc_sel` = 1.
- Retire with neither: `pc_sel` = 0.
- PC+1 is computed modulo 2^`PC_W`, so 1023 → 0 for `PC_W`=10.
- Targets are taken as-is. A target equal to the current PC is legal and refetches the same address.

Input qualification:
- `imem_ack` outside FETCH is ignored.
- `exec_done`, `branch_taken`, `jump` and `halt` are sampled only in EXEC.
- `stall`=1 in EXEC overrides `exec_done`: no retire, PC holds.

Retired counter:
- `retired` increments by 1 on every retire, including a halting retire.
- It saturates at all-ones.

## Timing
Reset values (asynchronous, while `reset`=0):
- state = IDLE, `pc` = `RESET_VEC`, `retired` = 0.
- `imem_req` = 0, `instr_valid` = 0, `halted` = 0, `pc_sel` = 3.
- Reset asserted mid-FETCH or mid-EXEC aborts immediately to these values; no retire is counted.

Output timing:
- `imem_req`, `imem_addr` and `halted` are Moore outputs of the registered state and PC.
- `next_pc` and `pc_sel` are combinational from the current state and inputs.

Latency:
- `start` sampled high at edge N: FETCH begins in cycle N+1.
- `imem_ack`=1 in the same cycle as `imem_req` is accepted at that edge.
- Minimum instruction period is 2 cycles: FETCH with ack, then EXEC with `exec_done`.
- New `pc` is visible the cycle after retire, together with `imem_req`=1.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum: IDLE, FETCH, EXEC, HALTED;
  - the `pc_sel` codes: SEL_INC, SEL_BR, SEL_JMP, SEL_HOLD;
  - the default `PC_W`.
- One sub-module, `pc_next_logic`, is combinational. It takes the priority inputs and produces `next_pc` and `pc_sel`.
- The FSM, PC register and counter live in the top level.

## Test plan
- Reset then `start`, with `imem_ack` and `exec_done` both 1 whenever sampled:
  - `pc` steps 0, 1, 2, 3 every 2 cycles;
  - `instr_valid` pulses once per instruction;
  - `retired` = 4 after four instructions.
- Retire in EXEC at `pc`=5 with `jump`=1 to 0x200 and `branch_taken`=1 to 0x010:
  - `pc_sel` = 2;
  - next fetch address = 0x200.
- `stall`=1 for 3 cycles with `exec_done`=1:
  - `pc` holds and `pc_sel` = 3 throughout;
  - retire occurs on the first cycle with `stall`=0.
- PC at 1023, normal retire:
  - `pc` = 0 next;
  - `retired` counter at all-ones stays all-ones after another retire.
- `halt`=1 together with `jump`=1 at retire:
  - `halted` = 1 and `pc` unchanged;
  - `retired` increments;
  - a later `start` has no effect.
- `reset` asserted low in FETCH with `imem_req`=1:
  - `pc` = `RESET_VEC` and `imem_req` = 0 immediately, without waiting for a clock edge;
  - `retired` = 0.
